// File: rtl/ascii2ps2_pkg.sv
// Shared types, PS/2 set-2 constants and sequence helpers for the ASCII-to-PS/2 sequencer.
package ascii2ps2_pkg;

    typedef enum logic [1:0] {NONE, SHIFT, CTRL} mod_t;
    typedef enum logic {IDLE, WRITE} seq_state_t;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_LCTRL  = 8'h14;

    typedef struct packed {
        logic [7:0] code;
        mod_t       mod;
        logic       ext;
        logic       valid;
    } key_t;

    function automatic logic [2:0] seq_len(mod_t mod, logic ext);
        if (ext) return 3'd5;
        if (mod != NONE) return 3'd6;
        return 3'd3;
    endfunction

    // Byte idx of the make/break sequence for one key.
    function automatic logic [7:0] seq_byte(logic [7:0] code, mod_t mod, logic ext, logic [2:0] idx);
        logic [7:0] m;
        m = (mod == CTRL) ? SC_LCTRL : SC_LSHIFT;
        seq_byte = code;
        if (ext) begin
            case (idx)
                3'd0, 3'd2: seq_byte = SC_EXT;
                3'd3:       seq_byte = SC_BREAK;
                default:    seq_byte = code;
            endcase
        end else if (mod != NONE) begin
            case (idx)
                3'd0, 3'd5: seq_byte = m;
                3'd2, 3'd4: seq_byte = SC_BREAK;
                default:    seq_byte = code;
            endcase
        end else if (idx == 3'd1) begin
            seq_byte = SC_BREAK;
        end
    endfunction

endpackage

// File: rtl/ascii2ps2_seq_if.sv
// Character input, PS/2 byte output and status bundle between host and sequencer.
interface ascii2ps2_if #(parameter int DEPTH = 16);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    ascii;
    logic          latch;
    logic          ready;
    logic [7:0]    scancode;
    logic          send;
    logic          busy;
    logic          dropped;
    logic [LW-1:0] level;

    modport master (output ascii, latch, ready,
                    input  scancode, send, busy, dropped, level);
    modport slave  (input  ascii, latch, ready,
                    output scancode, send, busy, dropped, level);
endinterface

// File: rtl/ascii2ps2_seq_translator.sv
// Combinational ASCII to PS/2 set-2 key lookup: base code, modifier and E0-extension flag.
module scancode_translator_ext
    import ascii2ps2_pkg::*;
(
    input  logic [7:0] ascii,
    output key_t       key
);

    function automatic logic [7:0] letter_code(logic [4:0] i);
        case (i)
            5'd0:  return 8'h1C;  5'd1:  return 8'h32;  5'd2:  return 8'h21;
            5'd3:  return 8'h23;  5'd4:  return 8'h24;  5'd5:  return 8'h2B;
            5'd6:  return 8'h34;  5'd7:  return 8'h33;  5'd8:  return 8'h43;
            5'd9:  return 8'h3B;  5'd10: return 8'h42;  5'd11: return 8'h4B;
            5'd12: return 8'h3A;  5'd13: return 8'h31;  5'd14: return 8'h44;
            5'd15: return 8'h4D;  5'd16: return 8'h15;  5'd17: return 8'h2D;
            5'd18: return 8'h1B;  5'd19: return 8'h2C;  5'd20: return 8'h3C;
            5'd21: return 8'h2A;  5'd22: return 8'h1D;  5'd23: return 8'h22;
            5'd24: return 8'h35;  default: return 8'h1A;
        endcase
    endfunction

    function automatic key_t mk(logic [7:0] code, mod_t mod, logic ext);
        return '{code: code, mod: mod, ext: ext, valid: 1'b1};
    endfunction

    // NOTE: default assigned first so every path drives key and no latch is inferred.
    always_comb begin
        key = '{code: 8'h00, mod: NONE, ext: 1'b0, valid: 1'b0};
        case (ascii)
            8'h20: key = mk(8'h29, NONE, 1'b0);
            8'h0D: key = mk(8'h5A, NONE, 1'b0);
            8'h08: key = mk(8'h66, NONE, 1'b0);
            8'h09: key = mk(8'h0D, NONE, 1'b0);
            8'h1B: key = mk(8'h76, NONE, 1'b0);
            8'h31: key = mk(8'h16, NONE, 1'b0);  8'h21: key = mk(8'h16, SHIFT, 1'b0);
            8'h32: key = mk(8'h1E, NONE, 1'b0);  8'h40: key = mk(8'h1E, SHIFT, 1'b0);
            8'h33: key = mk(8'h26, NONE, 1'b0);  8'h23: key = mk(8'h26, SHIFT, 1'b0);
            8'h34: key = mk(8'h25, NONE, 1'b0);  8'h24: key = mk(8'h25, SHIFT, 1'b0);
            8'h35: key = mk(8'h2E, NONE, 1'b0);  8'h25: key = mk(8'h2E, SHIFT, 1'b0);
            8'h36: key = mk(8'h36, NONE, 1'b0);  8'h5E: key = mk(8'h36, SHIFT, 1'b0);
            8'h37: key = mk(8'h3D, NONE, 1'b0);  8'h26: key = mk(8'h3D, SHIFT, 1'b0);
            8'h38: key = mk(8'h3E, NONE, 1'b0);  8'h2A: key = mk(8'h3E, SHIFT, 1'b0);
            8'h39: key = mk(8'h46, NONE, 1'b0);  8'h28: key = mk(8'h46, SHIFT, 1'b0);
            8'h30: key = mk(8'h45, NONE, 1'b0);  8'h29: key = mk(8'h45, SHIFT, 1'b0);
            8'h7F: key = mk(8'h71, NONE, 1'b1);
            8'h80: key = mk(8'h75, NONE, 1'b1);
            8'h81: key = mk(8'h72, NONE, 1'b1);
            8'h82: key = mk(8'h6B, NONE, 1'b1);
            8'h83: key = mk(8'h74, NONE, 1'b1);
            default: begin
                if (ascii >= 8'h61 && ascii <= 8'h7A)
                    key = mk(letter_code(5'(ascii - 8'h61)), NONE, 1'b0);
                else if (ascii >= 8'h41 && ascii <= 8'h5A)
                    key = mk(letter_code(5'(ascii - 8'h41)), SHIFT, 1'b0);
                else if (ascii >= 8'h01 && ascii <= 8'h1A)
                    key = mk(letter_code(5'(ascii - 8'h01)), CTRL, 1'b0);
            end
        endcase
    end

endmodule

// File: rtl/ascii2ps2_seq.sv
// Buffers whole PS/2 make/break sequences for each accepted character and emits one byte per send pulse.
module ascii2ps2_seq
    import ascii2ps2_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input logic          clk,
    input logic          reset_n,
    ascii2ps2_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);

    key_t          key_in;
    logic [2:0]    len_in;
    logic [LW-1:0] free;
    logic          accept, wr_en, rd_en;

    seq_state_t    state_q, state_d;
    logic [7:0]    code_q;
    mod_t          mod_q;
    logic          ext_q;
    logic [2:0]    len_q, idx_q;
    logic          dropped_q;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q;
    logic [7:0]    scancode_q;
    logic          send_q;

    scancode_translator_ext u_xlat (
        .ascii (bus.ascii),
        .key   (key_in)
    );

    // A sequence is only accepted when it fits entirely, so the FIFO never holds half a keystroke.
    assign len_in = seq_len(key_in.mod, key_in.ext);
    assign free   = LW'(DEPTH) - level_q;
    assign accept = bus.latch && key_in.valid && (state_q == IDLE) && (free >= LW'(len_in));
    assign wr_en  = (state_q == WRITE);
    assign rd_en  = !send_q && (level_q != '0) && bus.ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = WRITE;
            WRITE:   if (idx_q == len_q - 3'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            code_q    <= 8'h00;
            mod_q     <= NONE;
            ext_q     <= 1'b0;
            len_q     <= 3'd0;
            idx_q     <= 3'd0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dropped_q <= bus.latch && !accept;
            if (accept) begin
                code_q <= key_in.code;
                mod_q  <= key_in.mod;
                ext_q  <= key_in.ext;
                len_q  <= len_in;
                idx_q  <= 3'd0;
            end else if (wr_en) begin
                idx_q  <= idx_q + 3'd1;
            end
        end
    end

    // NOTE: storage has no reset; the pointers and level alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q] <= seq_byte(code_q, mod_q, ext_q, idx_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            scancode_q <= 8'h00;
            send_q     <= 1'b0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) begin
                rptr_q     <= rptr_q + 1'b1;
                scancode_q <= mem[rptr_q];
            end
            level_q <= level_q + LW'(wr_en) - LW'(rd_en);
            send_q  <= rd_en;
        end
    end

    assign bus.scancode = scancode_q;
    assign bus.send     = send_q;
    assign bus.busy     = (state_q == WRITE);
    assign bus.dropped  = dropped_q;
    assign bus.level    = level_q;

endmodule
